// File: rtl/half_adder_pkg.sv
// rtl/half_adder_pkg.sv - shared constants and helper functions for the half adder
package half_adder_pkg;

    localparam int MAX_WIDTH = 64;

    // The counter must hold WIDTH itself, so it is sized for WIDTH+1 distinct values.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int popcount(input logic [MAX_WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/half_adder_lane.sv
// rtl/half_adder_lane.sv - combinational single-bit half adder cell
module half_adder_lane (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - registered lane-parallel half adder; HALF_ADDER_STATS_EN adds sticky carry flag and txn counter
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = 1,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
`ifdef HALF_ADDER_STATS_EN
    ,
    output logic             any_carry_seen,
    output logic [31:0]      txn_count
`endif
);

    logic [WIDTH-1:0]     lane_sum;
    logic [WIDTH-1:0]     lane_carry;
    logic [MAX_WIDTH-1:0] carry_ext;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_lane u_lane (
            .a_i    (a[i]),
            .b_i    (b[i]),
            .sum_o  (lane_sum[i]),
            .carry_o(lane_carry[i])
        );
    end

    always_comb begin
        carry_ext = '0;
        carry_ext[WIDTH-1:0] = lane_carry;
    end

    // Data registers only load on a valid sample, so a/b are ignored while idle.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d   = lane_sum;
            carry_d = lane_carry;
            cnt_d   = CNT_W'(popcount(carry_ext));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign carry_cnt = cnt_q;
    assign out_valid = valid_q;

`ifdef HALF_ADDER_STATS_EN
    logic        seen_q, seen_d;
    logic [31:0] txn_q, txn_d;

    always_comb begin
        seen_d = seen_q | (in_valid & (|lane_carry));
        txn_d  = in_valid ? txn_q + 32'd1 : txn_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q <= 1'b0;
            txn_q  <= '0;
        end else begin
            seen_q <= seen_d;
            txn_q  <= txn_d;
        end
    end

    assign any_carry_seen = seen_q;
    assign txn_count      = txn_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - scoreboard bench for half_adder at WIDTH 1, 8 and 64
module tb_half_adder;

    typedef struct {
        logic [63:0] s;
        logic [63:0] c;
        int          n;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        v1, v8, v64;
    logic        a1, b1;
    logic [7:0]  a8, b8;
    logic [63:0] a64, b64;
    logic        s1, c1, ov1, ov8, ov64;
    logic        n1;
    logic [7:0]  s8, c8;
    logic [3:0]  n8;
    logic [63:0] s64, c64;
    logic [6:0]  n64;
`ifdef HALF_ADDER_STATS_EN
    logic        acs1, acs8, acs64;
    logic [31:0] tc1, tc8, tc64;
`endif

    exp_t q1[$];
    exp_t q8[$];
    exp_t q64[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    half_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1),
        .sum(s1), .carry(c1), .out_valid(ov1), .carry_cnt(n1)
`ifdef HALF_ADDER_STATS_EN
        , .any_carry_seen(acs1), .txn_count(tc1)
`endif
    );

    half_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8),
        .sum(s8), .carry(c8), .out_valid(ov8), .carry_cnt(n8)
`ifdef HALF_ADDER_STATS_EN
        , .any_carry_seen(acs8), .txn_count(tc8)
`endif
    );

    half_adder #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .in_valid(v64), .a(a64), .b(b64),
        .sum(s64), .carry(c64), .out_valid(ov64), .carry_cnt(n64)
`ifdef HALF_ADDER_STATS_EN
        , .any_carry_seen(acs64), .txn_count(tc64)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitors: pop the oldest expectation whenever a DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov1) begin
            if (q1.size() == 0) chk("w1_unexpected_output", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                chk("w1_sum", 64'(s1), e.s);
                chk("w1_carry", 64'(c1), e.c);
                chk("w1_cnt", 64'(n1), 64'(e.n));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov8) begin
            if (q8.size() == 0) chk("w8_unexpected_output", 64'd1, 64'd0);
            else begin
                e = q8.pop_front();
                chk("w8_sum", 64'(s8), e.s);
                chk("w8_carry", 64'(c8), e.c);
                chk("w8_cnt", 64'(n8), 64'(e.n));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov64) begin
            if (q64.size() == 0) chk("w64_unexpected_output", 64'd1, 64'd0);
            else begin
                e = q64.pop_front();
                chk("w64_sum", s64, e.s);
                chk("w64_carry", c64, e.c);
                chk("w64_cnt", 64'(n64), 64'(e.n));
                chk("w64_sum_and_carry", s64 & c64, 64'd0);
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v8 = 1'b0;
        v64 = 1'b0;
        a8 = 8'h3C;
        b8 = 8'hC3;
    endtask

    task automatic go1(input logic av, input logic bv, input logic se, input logic ce, input int ne);
        @(posedge clk);
        #1;
        v1 = 1'b1;
        a1 = av;
        b1 = bv;
        q1.push_back('{64'(se), 64'(ce), ne});
    endtask

    task automatic go8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] se,
                       input logic [7:0] ce, input int ne);
        @(posedge clk);
        #1;
        v8 = 1'b1;
        a8 = av;
        b8 = bv;
        q8.push_back('{64'(se), 64'(ce), ne});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] ra, rb;
        rst = 1'b0;
        v1 = 1'b0; v8 = 1'b0; v64 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0; a64 = '0; b64 = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset_ov1", 64'(ov1), 64'd0);
        chk("reset_sum8", 64'(s8), 64'd0);
        chk("reset_carry64", c64, 64'd0);
        chk("reset_cnt8", 64'(n8), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // WIDTH=1 truth table, back-to-back
        go1(1'b0, 1'b0, 1'b0, 1'b0, 0);
        go1(1'b0, 1'b1, 1'b1, 1'b0, 0);
        go1(1'b1, 1'b0, 1'b1, 1'b0, 0);
        go1(1'b1, 1'b1, 1'b0, 1'b1, 1);
        idle();
        idle();

        // Async reset while a result with sum=1 is on the outputs
        go1(1'b1, 1'b0, 1'b1, 1'b0, 0);
        @(posedge clk);
        #1 v1 = 1'b0;
        chk("pre_rst_valid", 64'(ov1), 64'd1);
        chk("pre_rst_sum", 64'(s1), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_ov", 64'(ov1), 64'd0);
        chk("async_rst_sum", 64'(s1), 64'd0);
        chk("async_rst_carry", 64'(c1), 64'd0);
        chk("async_rst_cnt", 64'(n1), 64'd0);
        q1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        chk("post_rst_idle", 64'(ov1), 64'd0);
        go1(1'b1, 1'b1, 1'b0, 1'b1, 1);
        idle();
        chk("first_out_latency", 64'(ov1), 64'd1);
        idle();
        chk("single_pulse", 64'(ov1), 64'd0);

        // WIDTH=8 hold with junk on a/b while idle
        go8(8'hF0, 8'hFF, 8'h0F, 8'hF0, 4);
        idle();
        chk("hold_pulse", 64'(ov8), 64'd1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("hold_ov", 64'(ov8), 64'd0);
            chk("hold_sum", 64'(s8), 64'h0F);
            chk("hold_carry", 64'(c8), 64'hF0);
            chk("hold_cnt", 64'(n8), 64'd4);
        end

        // Full carry, then alternating pattern
        go8(8'hFF, 8'hFF, 8'h00, 8'hFF, 8);
        go8(8'hAA, 8'h55, 8'hFF, 8'h00, 0);
        idle();
        idle();

        // WIDTH=64 random back-to-back
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            v64 = 1'b1;
            a64 = ra;
            b64 = rb;
            q64.push_back('{ra ^ rb, ra & rb, $countones(ra & rb)});
        end
        idle();
        idle();

`ifdef HALF_ADDER_STATS_EN
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) go8(8'h0F, 8'hF0, 8'hFF, 8'h00, 0);
        idle();
        chk("stats_no_carry", 64'(acs8), 64'd0);
        chk("stats_txn5", 64'(tc8), 64'd5);
        go8(8'h01, 8'h01, 8'h00, 8'h01, 1);
        idle();
        chk("stats_carry_seen", 64'(acs8), 64'd1);
        chk("stats_txn6", 64'(tc8), 64'd6);
        idle();
        idle();
        chk("stats_sticky", 64'(acs8), 64'd1);
        chk("stats_txn_hold", 64'(tc8), 64'd6);
        #1 rst = 1'b1;
        #1;
        chk("stats_rst_seen", 64'(acs8), 64'd0);
        chk("stats_rst_txn", 64'(tc8), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
`endif

        idle();
        idle();
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Registered, lane-parallel half adder. Each of WIDTH independent bit lanes computes sum = a XOR b and carry = a AND b.
- Results are registered with a valid qualifier, and a per-transaction carry population count is reported alongside.
- Sits as a leaf arithmetic primitive feeding full-adder/compressor stages in datapaths.
- WIDTH=1 gives the classic single-bit half adder.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (1..64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  a/b are valid this cycle
- a  input  WIDTH  addend A, one bit per lane
- b  input  WIDTH  addend B, one bit per lane
- sum  output  WIDTH  registered a XOR b per lane
- carry  output  WIDTH  registered a AND b per lane
- out_valid  output  1  sum/carry/carry_cnt hold a new result
- carry_cnt  output  CNT_W  registered count of set carry bits; CNT_W = $clog2(WIDTH+1), minimum 1

Behaviour:
- Reset: asynchronous assert clears sum, carry, carry_cnt and out_valid to 0 immediately. Deassertion is taken synchronously at the next clk edge.
- Latency: exactly 1 cycle. An in_valid=1 sample at edge N appears on the outputs after edge N, with out_valid=1 for that one cycle.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - sum, carry and carry_cnt hold their previous values; no X and no clearing.
- Truth table per lane (a,b -> sum,carry): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- sum and carry are never both 1 in the same lane.
- carry_cnt = number of 1s in the carry vector of the same transaction, range 0..WIDTH. No wrap, because CNT_W covers WIDTH.
- No backpressure. A new transaction is accepted every cycle that in_valid=1, and back-to-back inputs produce back-to-back outputs.
- Lanes are fully independent; no carry propagates between lanes.
- X/Z on a or b while in_valid=0 must not affect the outputs.
- Reset asserted mid-stream: the in-flight result is discarded and out_valid=0 on the first edge after release. The first valid output after reset comes 1 cycle after the first in_valid=1 sampled out of reset.

Optional Feature:
- Macro: HALF_ADDER_STATS_EN
- Defined:
  - Adds output any_carry_seen (1 bit), a sticky flag set on the edge where a valid transaction has carry != 0.
  - The flag is cleared only by rst.
  - Adds output txn_count (32 bits), which counts accepted in_valid cycles and wraps from 0xFFFFFFFF to 0.
  - Both outputs reset to 0.
- Undefined: these ports and registers do not exist, and core behaviour is identical.

Decomposition:
- Package half_adder_pkg:
  - function cnt_width(WIDTH) returning max(1, $clog2(WIDTH+1)).
  - popcount function.
  - Constant MAX_WIDTH=64.
- One natural sub-module, half_adder_lane: a purely combinational 1-bit a,b -> sum,carry cell, generated WIDTH times.
- The top module holds the registers, valid pipeline, popcount and optional stats.

Test Plan:
- WIDTH=1, after reset, drive in_valid=1 with (a,b) = 00, 01, 10, 11 on consecutive cycles -> one cycle later (sum,carry) = (0,0), (1,0), (1,0), (0,1), with out_valid=1 each cycle and carry_cnt 0, 0, 0, 1.
- Reset check: assert rst asynchronously mid-cycle while out_valid=1, sum=1 -> all outputs 0 before the next edge. First output after release appears 1 cycle after the first valid input.
- Hold check: WIDTH=8, a=0xF0, b=0xFF valid, then in_valid=0 for 3 cycles -> sum=0x0F, carry=0xF0, carry_cnt=4. out_valid pulses once, then sum/carry/carry_cnt hold while out_valid=0.
- Full carry: WIDTH=8, a=b=0xFF valid -> sum=0x00, carry=0xFF, carry_cnt=8 with no overflow. Then a=0xAA, b=0x55 -> sum=0xFF, carry=0x00, carry_cnt=0.
- Random lanes: WIDTH=64, 1000 random back-to-back valid vectors -> each output equals (a^b, a&b, popcount(a&b)) of the previous cycle's input. Check sum&carry==0.
- Stats (HALF_ADDER_STATS_EN): 5 valid transactions with carry=0 only -> any_carry_seen=0, txn_count=5. One more with a=b=1 -> any_carry_seen=1 and stays 1 until rst.
